// File: rtl/avalon_wait_ram_if.sv
// Avalon-MM bus between a CPU master and a slave memory.
// Ports: address/read/write/byteenable/writedata (m->s), waitrequest/readdata (s->m).
interface avalon_wait_ram_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with configurable wait states, byte lanes and preload.
// Ports: clk, reset (sync, high), bus (slave), load_en/addr/data, protocol_error.
module avalon_wait_ram #(
  parameter int          ADDR_BITS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_wait_ram_if.slave     bus,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [31:0]          load_data,
  output logic                 protocol_error
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int HI    = ADDR_BITS + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:2] cap_addr;
  logic        cap_rd;
  logic        cap_wr;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic                 req;
  logic                 changed;
  logic                 in_range;
  logic                 commit;
  logic [ADDR_BITS-1:0] cap_idx;
  logic                 unused_addr;

  assign req      = bus.read | bus.write;
  assign cap_idx  = cap_addr[HI-1:2];
  assign in_range = cap_addr[31:HI] == BASE_ADDR[31:HI];

  // The master must hold the request steady until waitrequest drops.
  assign changed = !req
                || bus.address[31:2] != cap_addr
                || bus.read  != cap_rd
                || bus.write != cap_wr;

  assign bus.waitrequest = req && state != S_DONE;
  assign unused_addr     = ^bus.address[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      cap_addr       <= '0;
      cap_rd         <= 1'b0;
      cap_wr         <= 1'b0;
      bus.readdata   <= '0;
      protocol_error <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            state    <= S_WAIT;
            cnt      <= 4'(WAIT_CYCLES - 1);
            cap_addr <= bus.address[31:2];
            cap_rd   <= bus.read;
            cap_wr   <= bus.write;
            if (bus.read && bus.write)
              protocol_error <= 1'b1;
          end
        end
        S_WAIT: begin
          if (changed) begin
            state          <= S_IDLE;
            protocol_error <= 1'b1;
          end else if (cnt == 4'd0) begin
            state <= S_DONE;
            // read+write collapses to a write: readdata untouched
            if (cap_rd && !cap_wr)
              bus.readdata <= in_range ? mem[cap_idx] : 32'h0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Preload overrides a bus write to the same word on the same edge.
  assign commit = !reset
               && state == S_DONE
               && cap_wr
               && in_range
               && !(load_en && load_addr == cap_idx);

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i])
          mem[cap_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
    if (load_en)
      mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Directed bench for avalon_wait_ram: vector table plus corner sequences.
// Drives the bus on negedge / posedge+1, samples just after negedge.
module tb_avalon_wait_ram;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        protocol_error;

  int errors = 0;
  int checks = 0;

  avalon_wait_ram_if bus();

  avalon_wait_ram #(
    .ADDR_BITS  (8),
    .BASE_ADDR  (32'h0000_0000),
    .WAIT_CYCLES(W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic start(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.byteenable = be;
    bus.writedata  = wd;
  endtask

  // Count waitrequest-high cycles; returns at negedge+1 of the DONE cycle.
  task automatic wait_done(output int n);
    n = 0;
    #1;
    while (bus.waitrequest && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic release_bus();
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    load_en   = 1'b0;
    @(negedge clk);
  endtask

  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd,
                        output logic [31:0] rdata, output int n);
    start(rd, wr, a, be, wd);
    wait_done(n);
    rdata = bus.readdata;
    release_bus();
  endtask

  vec_t        vecs [14];
  logic [31:0] rdata;
  int          n;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 32'h2402_0200};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 32'h0002_1202};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_000C, 4'hF, 32'h0, 32'h0000_0008};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0010, 4'h5, 32'hAABB_CCDD, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h00BB_00DD};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0400, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h5A5A_5A5A};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0014, 4'h0, 32'h1234_5678, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0014, 4'hF, 32'h0, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0018, 4'hF, 32'h0102_0304, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_001B, 4'hF, 32'h0, 32'h0102_0304};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0010, 4'hA, 32'h1122_3344, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h11BB_33DD};

    start(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_perr", 32'(protocol_error), 32'h0);
    check("rst_wreq_idle", 32'(bus.waitrequest), 32'h0);
    bus.read = 1'b1;
    #1;
    check("rst_wreq_req", 32'(bus.waitrequest), 32'h1);
    bus.read = 1'b0;
    @(negedge clk);

    // preload while reset is held
    preload(8'd1, 32'h2402_0200);
    preload(8'd2, 32'h0002_1202);
    preload(8'd3, 32'h0000_0008);
    preload(8'd0, 32'h5A5A_5A5A);
    preload(8'd4, 32'h0000_0000);
    preload(8'd5, 32'hCAFE_F00D);
    preload(8'd7, 32'h0000_0000);
    preload(8'd8, 32'h1357_9BDF);
    preload(8'd9, 32'h600D_CAFE);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be,
             vecs[i].wd, rdata, n);
      check($sformatf("v%0d_wait", i), 32'(n), 32'(W + 1));
      if (vecs[i].rd)
        check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp);
    end
    #1;
    check("hold_readdata", bus.readdata, 32'h11BB_33DD);
    check("perr_clean", 32'(protocol_error), 32'h0);

    // read and write together: acts as a write, flags an error
    access(1'b1, 1'b1, 32'h0000_001C, 4'hF, 32'h7777_7777, rdata, n);
    check("rw_wait", 32'(n), 32'(W + 1));
    check("rw_rdata_kept", rdata, 32'h11BB_33DD);
    check("rw_perr", 32'(protocol_error), 32'h1);
    access(1'b1, 1'b0, 32'h0000_001C, 4'hF, 32'h0, rdata, n);
    check("rw_committed", rdata, 32'h7777_7777);

    // drop the request one WAIT cycle into a write
    start(1'b0, 1'b1, 32'h0000_0020, 4'hF, 32'h9999_9999);
    @(negedge clk);
    #1;
    check("abort_wreq_wait", 32'(bus.waitrequest), 32'h1);
    bus.write = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort_wreq_idle", 32'(bus.waitrequest), 32'h0);
    check("abort_perr", 32'(protocol_error), 32'h1);
    access(1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, rdata, n);
    check("abort_wait", 32'(n), 32'(W + 1));
    check("abort_nochange", rdata, 32'h1357_9BDF);
    check("perr_sticky", 32'(protocol_error), 32'h1);

    // preload and bus write hit word 4 on the same edge
    start(1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'h2222_2222);
    wait_done(n);
    check("coll_wait", 32'(n), 32'(W + 1));
    load_en   = 1'b1;
    load_addr = 8'd4;
    load_data = 32'h1111_1111;
    release_bus();
    access(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, rdata, n);
    check("coll_preload_wins", rdata, 32'h1111_1111);

    // reset during WAIT of a write
    start(1'b0, 1'b1, 32'h0000_0024, 4'hF, 32'h0BAD_F00D);
    @(negedge clk);
    reset     = 1'b1;
    bus.write = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_perr", 32'(protocol_error), 32'h0);
    check("mid_rst_readdata", bus.readdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    access(1'b1, 1'b0, 32'h0000_0024, 4'hF, 32'h0, rdata, n);
    check("mid_rst_wait", 32'(n), 32'(W + 1));
    check("mid_rst_nocommit", rdata, 32'h600D_CAFE);
    check("mid_rst_perr_after", 32'(protocol_error), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
